multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: Moore FSM replacing the single-cycle decoder. Sequences each
//  instruction through FETCH/DECODE/EXEC/MEM/WB over a shared datapath and a unified memory with
//  a ready handshake. Adds memory wait states, a bus timeout, syscall halt/resume, illegal-op
//  flagging and a retire pulse. Sits between the external IR/ALU/regfile datapath and memory.
// PARAMETERS
//  ALU_W        5   width of alu_control (ADD=0, SUB=1, OR=2, LUI=3)
//  WAIT_TIMEOUT 15  max cycles waiting on mem_ready before error (>=1)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     reset, asynchronous, active-high
//  opcode         in   6     IR[31:26], stable from DECODE until return to FETCH
//  funct          in   6     IR[5:0]
//  alu_zero       in   1     ALU zero flag
//  mem_ready      in   1     memory completes current request this cycle
//  resume         in   1     leave HALT
//  mem_req        out  1     memory access request
//  mem_we         out  1     write (with mem_req)
//  i_or_d         out  1     0=PC address, 1=ALUOut address
//  ir_write       out  1     load IR
//  pc_write       out  1     unconditional PC load
//  pc_write_cond  out  1     PC load if alu_zero
//  pc_src         out  2     00=ALU, 01=ALUOut, 10=jump target, 11=rs
//  alu_src_a      out  1     0=PC, 1=rs
//  alu_src_b      out  2     00=rt, 01=const 4, 10=imm, 11=imm<<2 sign-ext
//  ext_zero       out  1     immediate zero-extended (ori)
//  alu_control    out  ALU_W ALU op
//  reg_write      out  1     regfile write
//  reg_dst        out  2     00=rt, 01=rd, 10=$ra
//  mem_to_reg     out  2     00=ALUOut, 01=MDR, 10=PC
//  halt           out  1     high in HALT
//  illegal_instr  out  1     1-cycle pulse on undecoded opcode/funct
//  bus_err        out  1     sticky until rst
//  instr_retired  out  1     1-cycle pulse on last cycle of each instruction
// BEHAVIOUR
//  - Outputs purely decoded from state (+opcode/funct); all outputs 0 during RESET state.
//  - rst -> state RESET, wait counter 0, bus_err 0; next cycle FETCH. Mid-op rst aborts instantly.
//  - FETCH: mem_req, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD; ir_write and pc_write asserted
//    only in the mem_ready cycle -> DECODE. Else stay.
//  - DECODE: alu_src_b=11, ADD (branch target to ALUOut). addu/subu->EXEC_R; ori/lui->EXEC_I;
//    lw/sw->MEM_ADDR; beq->BRANCH; j/jal/jr->JUMP; syscall->HALT; else illegal_instr,
//    instr_retired, ->FETCH.
//  - EXEC_R: alu_src_a=1, b=00, ADD/SUB -> ALU_WB(reg_dst=01). EXEC_I: a=1, b=10, OR(ext_zero=1)
//    or LUI -> ALU_WB(reg_dst=00). ALU_WB: reg_write, mem_to_reg=00, retire -> FETCH.
//  - MEM_ADDR: a=1, b=10, ADD -> MEM_READ (lw) / MEM_WRITE (sw).
//  - MEM_READ: mem_req, i_or_d=1; on mem_ready -> MEM_WB: reg_write, reg_dst=00, mem_to_reg=01,
//    retire. MEM_WRITE: mem_req, mem_we, i_or_d=1; on mem_ready retire -> FETCH.
//  - BRANCH: a=1, b=00, SUB, pc_write_cond, pc_src=01, retire -> FETCH.
//  - JUMP: pc_write; j pc_src=10; jal pc_src=10 + reg_write, reg_dst=10, mem_to_reg=10 (PC
//    already +4); jr pc_src=11. Retire -> FETCH.
//  - HALT: halt=1 until resume sampled high; then retire -> FETCH. resume elsewhere ignored.
//  - Wait counter: counts cycles in FETCH/MEM_READ/MEM_WRITE with mem_ready=0, clears on state
//    change. Reaching WAIT_TIMEOUT -> ERROR: bus_err=1, all other outputs 0, stays until rst.
//    mem_ready in the same cycle the count hits limit wins (normal advance).
// STRUCTURE
//  - control_pkg: state encodings (4 bit), ALU op codes, opcode/funct constants, mux selects.
//  - Sub-module wait_timer (clear, inc, WAIT_TIMEOUT -> expired); FSM and decode in this module.
// TESTING
//  - rst mid-MEM_READ -> RESET next edge, all outputs 0, then FETCH with mem_req=1.
//  - addu, mem_ready=1 -> 4 cycles FETCH,DECODE,EXEC_R,ALU_WB; reg_dst=01, one retire pulse.
//  - lw, mem_ready low 3 cycles in MEM_READ -> 8 cycles total; MEM_WB mem_to_reg=01.
//  - mem_ready held 0 in FETCH -> bus_err=1 after 15 waiting cycles, sticky until rst.
//  - beq alu_zero=1 -> pc_write_cond=1, pc_src=01; opcode 0x3F -> illegal_instr 1 cycle, FETCH.
//  - syscall -> halt=1 for 10 cycles, resume pulse -> FETCH next cycle; jal -> reg_dst=10.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, ALU ops,
// instruction fields and datapath mux selects.
package control_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_MEM_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12,
    S_ERROR     = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_LUI = 2'd3
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BR_OFS = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // States that sit on the memory handshake and are therefore bounded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the wait cycle that
// would reach WAIT_TIMEOUT.
module wait_timer #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // A ready in the limit cycle means inc is low, so the normal advance wins.
  assign expired = inc && (count == CW'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control unit for a multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back over a shared ALU and a unified memory.
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter int ALU_W        = 5,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [ALU_W-1:0] alu_control,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             halt,
  output logic             illegal_instr,
  output logic             bus_err,
  output logic             instr_retired
);

  state_e  state, next_state;
  alu_op_e alu_op;
  logic    timer_expired;

  // alu_zero gates pc_write_cond inside the datapath; the sequencer never branches on it.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (next_state != state),
    .inc     (is_wait_state(state) && !mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= next_state;
  end

  assign alu_control = ALU_W'(alu_op);

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    next_state    = state;
    alu_op        = ALU_ADD;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    ext_zero      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    halt          = 1'b0;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    instr_retired = 1'b0;

    unique case (state)
      S_RESET: next_state = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timer_expired) begin
          next_state = S_ERROR;
        end
      end

      S_DECODE: begin
        alu_src_b = SRC_B_BR_OFS;
        unique case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU) next_state = S_EXEC_R;
            else if (funct == FN_JR)                  next_state = S_JUMP;
            else if (funct == FN_SYSCALL)             next_state = S_HALT;
            else begin
              illegal_instr = 1'b1;
              instr_retired = 1'b1;
              next_state    = S_FETCH;
            end
          end
          OP_ORI, OP_LUI:     next_state = S_EXEC_I;
          OP_LW, OP_SW:       next_state = S_MEM_ADDR;
          OP_BEQ:             next_state = S_BRANCH;
          OP_J, OP_JAL:       next_state = S_JUMP;
          default: begin
            illegal_instr = 1'b1;
            instr_retired = 1'b1;
            next_state    = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_RT;
        alu_op     = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        next_state = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        if (opcode == OP_LUI) begin
          alu_op = ALU_LUI;
        end else begin
          alu_op   = ALU_OR;
          ext_zero = 1'b1;
        end
        next_state = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write     = 1'b1;
        reg_dst       = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)          next_state = S_MEM_WB;
        else if (timer_expired) next_state = S_ERROR;
      end

      S_MEM_WB: begin
        reg_write     = 1'b1;
        reg_dst       = DST_RT;
        mem_to_reg    = M2R_MDR;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          next_state    = S_FETCH;
        end else if (timer_expired) begin
          next_state = S_ERROR;
        end
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRC_B_RT;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end

      S_JUMP: begin
        pc_write      = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
        if (opcode == OP_RTYPE) begin
          pc_src = PC_SRC_RS;
        end else begin
          pc_src = PC_SRC_JUMP;
          // PC already holds the return address (+4) from FETCH.
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = M2R_PC;
          end
        end
      end

      S_HALT: begin
        halt = 1'b1;
        if (resume) begin
          instr_retired = 1'b1;
          next_state    = S_FETCH;
        end
      end

      S_ERROR: bus_err = 1'b1;

      default: next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each instruction pushes its expected
// retire-cycle profile, popped and compared when instr_retired pulses.
module tb_multicycle_control_fsm;

  localparam int ALU_W        = 5;
  localparam int WAIT_TIMEOUT = 15;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BAD = 6'h3F;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_SYS  = 6'h0C;
  localparam logic [5:0] F_BAD  = 6'h3F;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode, funct;
  logic             alu_zero, mem_ready, resume;
  logic             mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]       pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic             alu_src_a, ext_zero, reg_write, halt, illegal_instr, bus_err, instr_retired;
  logic [ALU_W-1:0] alu_control;

  multicycle_control_fsm #(.ALU_W(ALU_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .mem_ready     (mem_ready),
    .resume        (resume),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ext_zero      (ext_zero),
    .alu_control   (alu_control),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .halt          (halt),
    .illegal_instr (illegal_instr),
    .bus_err       (bus_err),
    .instr_retired (instr_retired)
  );

  always #5 clk = ~clk;

  // bus_err sits at bit 1 of this vector.
  logic [25:0] all_outs;
  assign all_outs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                     alu_src_a, alu_src_b, ext_zero, alu_control, reg_write, reg_dst,
                     mem_to_reg, halt, illegal_instr, bus_err, instr_retired};

  typedef struct {
    int         cycles;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] mtr;
    logic       pw;
    logic       pwc;
    logic [1:0] psrc;
    logic       we;
    logic       ill;
    logic [4:0] alu3;
    int         halts;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t mk(input int cycles, input logic rw, input logic [1:0] rd,
                              input logic [1:0] mtr, input logic pw, input logic pwc,
                              input logic [1:0] psrc, input logic we, input logic ill,
                              input logic [4:0] alu3, input int halts);
    exp_t e;
    e.cycles = cycles; e.rw = rw; e.rd = rd; e.mtr = mtr; e.pw = pw; e.pwc = pwc;
    e.psrc = psrc; e.we = we; e.ill = ill; e.alu3 = alu3; e.halts = halts;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH; mem_ready is low for cycles [ws, ws+wn); resume pulses on
  // cycle 1 (must be ignored) and on res_cyc.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic zero, input int ws, input int wn, input int res_cyc,
                     input exp_t e);
    exp_t       want;
    bit         done  = 1'b0;
    int         halts = 0;
    logic [4:0] alu3  = '0;
    sb.push_back(e);
    opcode = op; funct = fn; alu_zero = zero;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      mem_ready = !(cyc >= ws && cyc < ws + wn);
      resume    = (cyc == 1) || (cyc == res_cyc);
      #1;
      if (cyc == 1) check({name, "/fetch_req"}, {30'd0, mem_req, i_or_d}, 32'd2);
      if (cyc == 3) alu3 = alu_control;
      if (halt) halts++;
      if (instr_retired) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          check({name, "/sb_empty"}, 32'd0, 32'd1);
        end else begin
          want = sb.pop_front();
          check({name, "/cycles"},      cyc,           want.cycles);
          check({name, "/reg_write"},   reg_write,     want.rw);
          check({name, "/reg_dst"},     reg_dst,       want.rd);
          check({name, "/mem_to_reg"},  mem_to_reg,    want.mtr);
          check({name, "/pc_write"},    pc_write,      want.pw);
          check({name, "/pc_wr_cond"},  pc_write_cond, want.pwc);
          check({name, "/pc_src"},      pc_src,        want.psrc);
          check({name, "/mem_we"},      mem_we,        want.we);
          check({name, "/illegal"},     illegal_instr, want.ill);
          if (want.cycles >= 3) check({name, "/alu_cyc3"}, alu3, want.alu3);
          check({name, "/halt_cycles"}, halts,         want.halts);
        end
      end
      step();
    end
    if (!done) begin
      check({name, "/retire_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
    mem_ready = 1'b0; resume = 1'b0;
    #1;
    check({name, "/back_to_fetch"}, {28'd0, mem_req, i_or_d, instr_retired, halt}, 32'h8);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    #2;
    check("reset_async_outs", all_outs, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("reset_state_outs", all_outs, 32'd0);
    step();
    check("fetch_after_reset", {mem_req, i_or_d, alu_src_b, alu_control}, {1'b1, 1'b0, 2'b01, 5'd0});

    //        name        op      fn      z     ws wn res  cyc rw rd mtr pw pwc psrc we ill alu h
    run("addu",      OP_R,   F_ADDU, 1'b0, 0, 0,  0, mk(4,  1, 1, 0,  0, 0,  0,   0, 0,  0,  0));
    run("subu",      OP_R,   F_SUBU, 1'b0, 0, 0,  0, mk(4,  1, 1, 0,  0, 0,  0,   0, 0,  1,  0));
    run("ori",       OP_ORI, 6'h00,  1'b0, 0, 0,  0, mk(4,  1, 0, 0,  0, 0,  0,   0, 0,  2,  0));
    run("lui",       OP_LUI, 6'h00,  1'b0, 0, 0,  0, mk(4,  1, 0, 0,  0, 0,  0,   0, 0,  3,  0));
    run("lw_wait3",  OP_LW,  6'h00,  1'b0, 4, 3,  0, mk(8,  1, 0, 1,  0, 0,  0,   0, 0,  0,  0));
    run("sw",        OP_SW,  6'h00,  1'b0, 0, 0,  0, mk(4,  0, 0, 0,  0, 0,  0,   1, 0,  0,  0));
    run("beq",       OP_BEQ, 6'h00,  1'b1, 0, 0,  0, mk(3,  0, 0, 0,  0, 1,  1,   0, 0,  1,  0));
    run("j",         OP_J,   6'h00,  1'b0, 0, 0,  0, mk(3,  0, 0, 0,  1, 0,  2,   0, 0,  0,  0));
    run("jal",       OP_JAL, 6'h00,  1'b0, 0, 0,  0, mk(3,  1, 2, 2,  1, 0,  2,   0, 0,  0,  0));
    run("jr",        OP_R,   F_JR,   1'b0, 0, 0,  0, mk(3,  0, 0, 0,  1, 0,  3,   0, 0,  0,  0));
    run("syscall",   OP_R,   F_SYS,  1'b0, 0, 0, 12, mk(12, 0, 0, 0,  0, 0,  0,   0, 0,  0, 10));
    run("bad_op",    OP_BAD, 6'h00,  1'b0, 0, 0,  0, mk(2,  0, 0, 0,  0, 0,  0,   0, 1,  0,  0));
    run("bad_funct", OP_R,   F_BAD,  1'b0, 0, 0,  0, mk(2,  0, 0, 0,  0, 0,  0,   0, 1,  0,  0));
    run("addu_fw2",  OP_R,   F_ADDU, 1'b0, 1, 2,  0, mk(6,  1, 1, 0,  0, 0,  0,   0, 0,  0,  0));
    run("lw_wait14", OP_LW,  6'h00,  1'b0, 4, 14, 0, mk(19, 1, 0, 1,  0, 0,  0,   0, 0,  0,  0));

    // Reset in the middle of a stalled load.
    opcode = OP_LW; funct = '0; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    check("midrd_in_mem_read", {30'd0, mem_req, i_or_d}, 32'd3);
    step();
    rst = 1'b1;
    #1;
    check("midrd_rst_outs", all_outs, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("midrd_reset_state", all_outs, 32'd0);
    step();
    check("midrd_fetch", {30'd0, mem_req, i_or_d}, 32'd2);

    // Fetch timeout: 15 unanswered cycles, then sticky bus error.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mem_ready = 1'b0;
    for (int k = 1; k <= WAIT_TIMEOUT; k++) begin
      #1;
      if (k == WAIT_TIMEOUT) check("to_last_wait", {30'd0, mem_req, bus_err}, 32'd2);
      step();
    end
    check("to_bus_err", all_outs, 32'd2);
    mem_ready = 1'b1; resume = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("to_sticky", all_outs, 32'd2);
    rst = 1'b1;
    #1;
    check("to_rst_clears", all_outs, 32'd0);
    step();
    rst = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    step();
    run("addu_after_err", OP_R, F_ADDU, 1'b0, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
